// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "rooth_defines.v"

package wb_arbiter_pkg;

    localparam int ADDR_W = `REG_ADDR_WIDTH;
    localparam int DATA_W = `CPU_WIDTH;
    localparam int NREG   = 1 << ADDR_W;

    // One buffered long-latency result
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    // Source chosen for the output register on a given edge
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_EX   = 2'd1,
        SEL_LL   = 2'd2
    } wb_sel_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of all wb_arbiter handshake, hazard and register-file signals.
// Latency: n/a (wiring only); slave = arbiter side, master = core side.
// Backpressure: ll_valid_i/ll_ready_o on the LL path; EX path has none.
// WB_BYPASS_EN adds the rsX_fwd_vld_o / rsX_fwd_data_o signals.
`include "rooth_defines.v"

interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic              ex_wr_en_i;
    logic [ADDR_W-1:0] ex_wr_addr_i;
    logic [DATA_W-1:0] ex_wr_data_i;
    logic              ll_valid_i;
    logic              ll_ready_o;
    logic [ADDR_W-1:0] ll_addr_i;
    logic [DATA_W-1:0] ll_data_i;
    logic              issue_ll_i;
    logic [ADDR_W-1:0] issue_addr_i;
    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic              rs1_busy_o;
    logic              rs2_busy_o;
    logic              wb_stall_o;
    logic              reg_wr_en_o;
    logic [ADDR_W-1:0] reg_wr_adder_o;
    logic [DATA_W-1:0] reg_wr_data_o;
`ifdef WB_BYPASS_EN
    logic              rs1_fwd_vld_o;
    logic [DATA_W-1:0] rs1_fwd_data_o;
    logic              rs2_fwd_vld_o;
    logic [DATA_W-1:0] rs2_fwd_data_o;
`endif

    modport slave (
        input  ex_wr_en_i, ex_wr_addr_i, ex_wr_data_i,
        input  ll_valid_i, ll_addr_i, ll_data_i,
        input  issue_ll_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
`ifdef WB_BYPASS_EN
        output rs1_fwd_vld_o, rs1_fwd_data_o, rs2_fwd_vld_o, rs2_fwd_data_o,
`endif
        output ll_ready_o, rs1_busy_o, rs2_busy_o, wb_stall_o,
        output reg_wr_en_o, reg_wr_adder_o, reg_wr_data_o
    );

    modport master (
        output ex_wr_en_i, ex_wr_addr_i, ex_wr_data_i,
        output ll_valid_i, ll_addr_i, ll_data_i,
        output issue_ll_i, issue_addr_i, rs1_addr_i, rs2_addr_i,
`ifdef WB_BYPASS_EN
        input  rs1_fwd_vld_o, rs1_fwd_data_o, rs2_fwd_vld_o, rs2_fwd_data_o,
`endif
        input  ll_ready_o, rs1_busy_o, rs2_busy_o, wb_stall_o,
        input  reg_wr_en_o, reg_wr_adder_o, reg_wr_data_o
    );

endinterface

// File: rtl/rooth_defines.v
// Core-wide width macros plus writeback arbiter parameter defaults.
// Pure preprocessor content, guarded so any file may include it.
// WB_BYPASS_EN is not defined here; it is a build option for wb_arbiter.
`ifndef ROOTH_DEFINES_V
`define ROOTH_DEFINES_V

`define REG_ADDR_WIDTH  5
`define CPU_WIDTH       32

// wb_arbiter parameter defaults
`define WB_LL_DEPTH     2
`define WB_STARVE_LIMIT 4

`endif

// File: rtl/wb_arbiter_ll_fifo.sv
// Buffer for long-latency {addr,data} results awaiting the register file write port.
// Latency: pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; count feeds ready.
// Ports: clk, rst (async, active-high), push/push_dat, pop/pop_dat, full, empty, count.
`include "rooth_defines.v"

module wb_ll_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = `WB_LL_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_ent_t                  push_dat,
    input  logic                     pop,
    output wb_ent_t                  pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    wb_ent_t     mem_q [DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_dat;
    end

    // Extra pointer bit distinguishes full from empty.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_dat = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EX and buffered long-latency results onto the single RF write port.
// Latency: 1 cycle to reg_wr_*; LL accepted at edge N reaches reg_wr_en_o at edge N+1.
// Backpressure: EX has none (wins always); LL via ll_ready_o, wb_stall_o asks core to idle EX.
// Ports: clk, rst (async, active-high), bus (wb_arbiter_if.slave).
// Build option WB_BYPASS_EN: adds rsX_fwd_* outputs and drops the output-register busy term.
`include "rooth_defines.v"

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LL_DEPTH     = `WB_LL_DEPTH,
    parameter int STARVE_LIMIT = `WB_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_sel_t                  sel;
    logic                     ex_sel;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(LL_DEPTH):0] fifo_cnt;
    wb_ent_t                  fifo_in;
    wb_ent_t                  fifo_head;

    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;
    logic              ll_ready_q, ll_ready_d;
    logic              stall_q,    stall_d;
    logic [CNT_W-1:0]  starve_q,   starve_d;
    logic [NREG-1:0]   pending_q,  pending_d;

    // EX to x0 is dropped, leaving the slot free for the FIFO.
    assign ex_sel    = bus.ex_wr_en_i && (bus.ex_wr_addr_i != '0);
    // LL to x0 completes the handshake but is never stored.
    assign fifo_push = bus.ll_valid_i && ll_ready_q && (bus.ll_addr_i != '0);
    assign fifo_in   = '{addr: bus.ll_addr_i, data: bus.ll_data_i};
    assign fifo_pop  = (sel == SEL_LL);

    wb_ll_fifo #(.DEPTH(LL_DEPTH)) u_ll_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        sel       = SEL_NONE;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (ex_sel) begin
            sel       = SEL_EX;
            wr_en_d   = 1'b1;
            wr_addr_d = bus.ex_wr_addr_i;
            wr_data_d = bus.ex_wr_data_i;
        end else if (!fifo_empty) begin
            sel       = SEL_LL;
            wr_en_d   = 1'b1;
            wr_addr_d = fifo_head.addr;
            wr_data_d = fifo_head.data;
        end
    end

    // Ready is computed from occupancy after this edge, so a full FIFO refuses
    // a push even when it pops in the same cycle.
    always_comb begin
        ll_ready_d = (int'(fifo_cnt) + int'(fifo_push) - int'(fifo_pop)) < LL_DEPTH;
    end

    // Clear on pop first, then set, so a same-index set wins.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) pending_d[fifo_head.addr] = 1'b0;
        if (bus.issue_ll_i && (bus.issue_addr_i != '0)) pending_d[bus.issue_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Saturating wait counter for the FIFO head; EX keeps priority even while stalling.
    always_comb begin
        starve_d = starve_q;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (!fifo_empty && (starve_q < CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d >= CNT_W'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ll_ready_q <= 1'b0;
            stall_q    <= 1'b0;
            starve_q   <= '0;
            pending_q  <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ll_ready_q <= ll_ready_d;
            stall_q    <= stall_d;
            starve_q   <= starve_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.reg_wr_en_o    = wr_en_q;
    assign bus.reg_wr_adder_o = wr_addr_q;
    assign bus.reg_wr_data_o  = wr_data_q;
    assign bus.ll_ready_o     = ll_ready_q;
    assign bus.wb_stall_o     = stall_q;

    // Output register holds a value the RF has not written yet.
    logic rs1_hit, rs2_hit;
    assign rs1_hit = wr_en_q && (wr_addr_q == bus.rs1_addr_i) && (bus.rs1_addr_i != '0);
    assign rs2_hit = wr_en_q && (wr_addr_q == bus.rs2_addr_i) && (bus.rs2_addr_i != '0);

`ifdef WB_BYPASS_EN
    assign bus.rs1_fwd_vld_o  = rs1_hit;
    assign bus.rs1_fwd_data_o = wr_data_q;
    assign bus.rs2_fwd_vld_o  = rs2_hit;
    assign bus.rs2_fwd_data_o = wr_data_q;
    assign bus.rs1_busy_o     = pending_q[bus.rs1_addr_i];
    assign bus.rs2_busy_o     = pending_q[bus.rs2_addr_i];
`else
    assign bus.rs1_busy_o     = pending_q[bus.rs1_addr_i] || rs1_hit;
    assign bus.rs2_busy_o     = pending_q[bus.rs2_addr_i] || rs2_hit;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scoreboard of expected RF writes plus per-cycle model.
// Latency: checks 1 time unit after each rising edge.
// Backpressure: LL offers are held until the modelled handshake completes.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int LL_DEPTH     = `WB_LL_DEPTH;
    localparam int STARVE_LIMIT = `WB_STARVE_LIMIT;

    logic clk;
    logic rst;
    wb_arbiter_if bus();

    wb_arbiter #(.LL_DEPTH(LL_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    wb_ent_t           m_fifo[$];
    wb_ent_t           exp_q[$];
    bit                m_ready, m_en, m_stall;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    bit   [NREG-1:0]   m_pend;
    int                m_cnt;
    bit                last_acc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_ready = 0; m_en = 0; m_stall = 0;
        m_addr = '0; m_data = '0; m_pend = '0; m_cnt = 0;
    endtask

    task automatic idle_inputs();
        bus.ex_wr_en_i = 0; bus.ex_wr_addr_i = '0; bus.ex_wr_data_i = '0;
        bus.ll_valid_i = 0; bus.ll_addr_i = '0; bus.ll_data_i = '0;
        bus.issue_ll_i = 0; bus.issue_addr_i = '0;
    endtask

    task automatic check_outputs();
        wb_ent_t e;
        bit b1, b2;
        chk("wr_en", bus.reg_wr_en_o, m_en);
        chk("wr_addr_hold", bus.reg_wr_adder_o, m_addr);
        chk("wr_data_hold", bus.reg_wr_data_o, m_data);
        if (bus.reg_wr_en_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", bus.reg_wr_adder_o, e.addr);
                chk("sb_data", bus.reg_wr_data_o, e.data);
            end
        end
        chk("ll_ready", bus.ll_ready_o, m_ready);
        chk("wb_stall", bus.wb_stall_o, m_stall);
`ifdef WB_BYPASS_EN
        b1 = (bus.rs1_addr_i != 0) && m_pend[bus.rs1_addr_i];
        b2 = (bus.rs2_addr_i != 0) && m_pend[bus.rs2_addr_i];
        chk("rs1_fwd_vld", bus.rs1_fwd_vld_o, m_en && (m_addr == bus.rs1_addr_i) && (bus.rs1_addr_i != 0));
        chk("rs2_fwd_vld", bus.rs2_fwd_vld_o, m_en && (m_addr == bus.rs2_addr_i) && (bus.rs2_addr_i != 0));
        if (bus.rs1_fwd_vld_o === 1'b1) chk("rs1_fwd_data", bus.rs1_fwd_data_o, m_data);
`else
        b1 = (bus.rs1_addr_i != 0) && (m_pend[bus.rs1_addr_i] || (m_en && m_addr == bus.rs1_addr_i));
        b2 = (bus.rs2_addr_i != 0) && (m_pend[bus.rs2_addr_i] || (m_en && m_addr == bus.rs2_addr_i));
`endif
        chk("rs1_busy", bus.rs1_busy_o, b1);
        chk("rs2_busy", bus.rs2_busy_o, b2);
    endtask

    // Advance the model across the coming edge using the driven inputs, then check.
    task automatic tick();
        bit nonempty, popped;
        wb_ent_t e;
        last_acc = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.issue_ll_i && bus.issue_addr_i != 0)
                assert (!m_pend[bus.issue_addr_i]) else $error("bench issued to pending rd");
            if (bus.ex_wr_en_i && bus.ex_wr_addr_i != 0)
                assert (!m_pend[bus.ex_wr_addr_i]) else $error("bench EX-wrote pending rd");
            nonempty = (m_fifo.size() > 0);
            popped   = 0;
            if (bus.ex_wr_en_i && bus.ex_wr_addr_i != 0) begin
                e = '{addr: bus.ex_wr_addr_i, data: bus.ex_wr_data_i};
                exp_q.push_back(e);
                m_en = 1; m_addr = e.addr; m_data = e.data;
            end else if (nonempty) begin
                e = m_fifo.pop_front();
                exp_q.push_back(e);
                m_en = 1; m_addr = e.addr; m_data = e.data;
                m_pend[e.addr] = 0;
                popped = 1;
            end else begin
                m_en = 0;
            end
            last_acc = bus.ll_valid_i && m_ready;
            if (last_acc && bus.ll_addr_i != 0)
                m_fifo.push_back('{addr: bus.ll_addr_i, data: bus.ll_data_i});
            if (bus.issue_ll_i && bus.issue_addr_i != 0) m_pend[bus.issue_addr_i] = 1;
            m_ready = (m_fifo.size() < LL_DEPTH);
            if (popped) m_cnt = 0;
            else if (nonempty && m_cnt < STARVE_LIMIT) m_cnt++;
            m_stall = (m_cnt >= STARVE_LIMIT);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        bus.issue_ll_i = 1; bus.issue_addr_i = a;
        tick();
        bus.issue_ll_i = 0; bus.issue_addr_i = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ADDR_W-1:0] offers [3];
        int off, n_acc;
        bit saw_stall;

        rst = 1;
        idle_inputs();
        bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
        model_reset();
        #2;
        check_outputs();                       // reset state
        tick();
        rst = 0;
        tick();
        chk("rst_release_ready", bus.ll_ready_o, 1);

        // 1: EX only
        bus.ex_wr_en_i = 1; bus.ex_wr_addr_i = 5; bus.ex_wr_data_i = 32'h1234;
        tick();
        chk("t1_en", bus.reg_wr_en_o, 1);
        chk("t1_addr", bus.reg_wr_adder_o, 5);
        chk("t1_data", bus.reg_wr_data_o, 32'h1234);
        idle_inputs();
        tick();

        // 2: simultaneous EX x3 and LL x7
        bus.rs1_addr_i = 7;
        issue(7);
        bus.ex_wr_en_i = 1; bus.ex_wr_addr_i = 3; bus.ex_wr_data_i = 32'hA;
        bus.ll_valid_i = 1; bus.ll_addr_i = 7; bus.ll_data_i = 32'hB;
        tick();
        chk("t2_first", bus.reg_wr_adder_o, 3);
        idle_inputs();
        tick();
        chk("t2_second", bus.reg_wr_adder_o, 7);
        chk("t2_second_data", bus.reg_wr_data_o, 32'hB);
        tick();
        chk("t2_pend_clear", bus.rs1_busy_o, 0);

        // 3: full FIFO under continuous EX traffic
        offers[0] = 10; offers[1] = 11; offers[2] = 12;
        bus.rs1_addr_i = 10; bus.rs2_addr_i = 12;
        for (int i = 0; i < 3; i++) issue(offers[i]);
        off = 0; n_acc = 0; saw_stall = 0;
        for (int i = 0; i < 10; i++) begin
            bus.ex_wr_en_i = 1; bus.ex_wr_addr_i = ADDR_W'(20 + i);
            bus.ex_wr_data_i = 32'h5000 + i;
            bus.ll_valid_i = (off < 3);
            if (off < 3) begin
                bus.ll_addr_i = offers[off];
                bus.ll_data_i = 32'hC000_0000 | offers[off];
            end
            tick();
            if (last_acc) begin off++; n_acc++; end
            if (bus.wb_stall_o) saw_stall = 1;
        end
        chk("t3_accepts", n_acc, 2);
        chk("t3_stall_seen", saw_stall, 1);
        bus.ex_wr_en_i = 0;
        for (int i = 0; i < 6; i++) begin
            bus.ll_valid_i = (off < 3);
            if (off < 3) begin
                bus.ll_addr_i = offers[off];
                bus.ll_data_i = 32'hC000_0000 | offers[off];
            end
            tick();
            if (last_acc) off++;
        end
        chk("t3_all_accepted", off, 3);
        idle_inputs();
        tick();

        // 4: hazard on x9
        bus.rs1_addr_i = 9; bus.rs2_addr_i = 0;
        issue(9);
        chk("t4_busy_pending", bus.rs1_busy_o, 1);
        tick();
        tick();
        bus.ll_valid_i = 1; bus.ll_addr_i = 9; bus.ll_data_i = 32'h99;
        tick();
        idle_inputs();
        tick();                                // x9 pops into output register
        chk("t4_pop_addr", bus.reg_wr_adder_o, 9);
        tick();
        chk("t4_busy_gone", bus.rs1_busy_o, 0);

        // 5: x0 writes
        bus.ex_wr_en_i = 1; bus.ex_wr_addr_i = 0; bus.ex_wr_data_i = 32'hDEAD;
        bus.ll_valid_i = 1; bus.ll_addr_i = 0; bus.ll_data_i = 32'hBEEF;
        tick();
        chk("t5_ll_handshake", last_acc, 1);
        chk("t5_no_write", bus.reg_wr_en_o, 0);
        idle_inputs();
        tick();
        chk("t5_still_idle", bus.reg_wr_en_o, 0);

        // 6: reset with two FIFO entries
        bus.rs1_addr_i = 13; bus.rs2_addr_i = 14;
        issue(13);
        issue(14);
        bus.ex_wr_en_i = 1; bus.ex_wr_addr_i = 21; bus.ex_wr_data_i = 32'h21;
        bus.ll_valid_i = 1; bus.ll_addr_i = 13; bus.ll_data_i = 32'h13;
        tick();
        bus.ex_wr_addr_i = 22; bus.ex_wr_data_i = 32'h22;
        bus.ll_addr_i = 14; bus.ll_data_i = 32'h14;
        tick();
        chk("t6_fifo_full", bus.ll_ready_o, 0);
        idle_inputs();
        #3;
        rst = 1;
        #1;
        model_reset();
        check_outputs();
        chk("t6_en_zero", bus.reg_wr_en_o, 0);
        chk("t6_addr_zero", bus.reg_wr_adder_o, 0);
        tick();
        rst = 0;
        tick();
        chk("t6_ready_after", bus.ll_ready_o, 1);
        tick();
        chk("t6_no_stale", bus.reg_wr_en_o, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
